// File: rtl/operand_skew_feeder_pkg.sv
// Shared types and helpers for the systolic-array operand skew feeder.
package sa_feed_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_e;

  // Upper bounds for the generic lane_slice helper (vector and lane widths).
  localparam int MAX_VEC    = 4096;
  localparam int MAX_LANE_W = 256;

  function automatic int drain_cnt_w(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

  // Returns lane i of a packed vector in the low bits; caller truncates to its width.
  function automatic logic [MAX_LANE_W-1:0] lane_slice(input logic [MAX_VEC-1:0] vec,
                                                        input int i, input int width);
    logic [MAX_VEC-1:0] sh;
    sh = vec >> (i * width);
    return sh[MAX_LANE_W-1:0];
  endfunction

endpackage

// File: rtl/operand_skew_feeder_delay.sv
// skew_delay_line: DEPTH-stage synchronous-reset register chain for one lane.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage[0] <= d;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/operand_skew_feeder.sv
// Diagonal operand skew feeder for the systolic-array edge, with tile drain tracking.
// Optional per-lane parity through the delay lines: define OPERAND_SKEW_FEEDER_PARITY_EN.
module operand_skew_feeder
  import sa_feed_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_valid,
  output logic                   tile_done,
  output logic                   busy,
  output logic [LANES-1:0]       out_par_err,
  output feeder_state_e          dbg_state
);

  localparam int CW = drain_cnt_w(LANES);
`ifdef OPERAND_SKEW_FEEDER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int SW = WIDTH + 1 + PB;

  // Handshake: a vector transfers only in a cycle where in_valid && in_ready;
  // in_last is meaningful only in that cycle. The output side has no backpressure.
  feeder_state_e state, state_nx;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, STREAM: begin
        if (accept) begin
          if (in_last) state_nx = (LANES == 1) ? IDLE : DRAIN;
          else         state_nx = STREAM;
        end
      end
      DRAIN:   if (cnt == CW'(1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state != DRAIN);
    busy      = (state != IDLE);
    dbg_state = state;
  end

  // Drain counter spans the LANES-1 cycles the last vector needs to clear the deepest lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= (LANES == 1) ? (accept && in_last) : (state == DRAIN && cnt == CW'(1));
      if (state != DRAIN && state_nx == DRAIN) cnt <= CW'(LANES - 1);
      else if (state == DRAIN)                 cnt <= cnt - CW'(1);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] lane_d;
    logic [SW-1:0]    din;
    logic [SW-1:0]    dout;

    assign lane_d = WIDTH'(lane_slice(MAX_VEC'(in_data), i, WIDTH));
`ifdef OPERAND_SKEW_FEEDER_PARITY_EN
    assign din = accept ? {1'b1, ^lane_d, lane_d} : '0;
`else
    assign din = accept ? {1'b1, lane_d} : '0;
`endif

    skew_delay_line #(.DEPTH(i + 1), .WIDTH(SW)) u_dl (
      .clk (clk),
      .rst (rst),
      .d   (din),
      .q   (dout)
    );

    assign out_valid[i]                = dout[SW-1];
    assign out_data[i*WIDTH +: WIDTH]  = dout[WIDTH-1:0];
`ifdef OPERAND_SKEW_FEEDER_PARITY_EN
    assign out_par_err[i] = dout[SW-1] && ((^dout[WIDTH-1:0]) != dout[WIDTH]);
`else
    assign out_par_err[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Bench for operand_skew_feeder: 4-lane and 1-lane instances against a cycle-indexed history model.
module tb_operand_skew_feeder;
  import sa_feed_pkg::*;

  localparam int LANES = 4;
  localparam int WIDTH = 8;
  localparam int VW    = LANES * WIDTH;
  localparam int NCYC  = 4000;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic [VW-1:0]    in_data  = '0;
  logic             in_last  = 1'b0;
  logic             in_ready, tile_done, busy;
  logic [VW-1:0]    out_data;
  logic [LANES-1:0] out_valid, out_par_err;
  feeder_state_e    dbg_state;

  logic             in_ready1, tile_done1, busy1;
  logic [WIDTH-1:0] out_data1;
  logic [0:0]       out_valid1, out_par_err1;
  feeder_state_e    dbg_state1;

  operand_skew_feeder #(.LANES(LANES), .WIDTH(WIDTH)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_data(out_data), .out_valid(out_valid), .tile_done(tile_done),
    .busy(busy), .out_par_err(out_par_err), .dbg_state(dbg_state)
  );

  operand_skew_feeder #(.LANES(1), .WIDTH(WIDTH)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data[WIDTH-1:0]),
    .in_last(in_last), .out_data(out_data1), .out_valid(out_valid1), .tile_done(tile_done1),
    .busy(busy1), .out_par_err(out_par_err1), .dbg_state(dbg_state1)
  );

  // scoreboard: per-cycle history of offered vectors and what each instance accepted
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic          hv  [NCYC];
  logic          hv1 [NCYC];
  logic          hl  [NCYC];
  logic [VW-1:0] hd  [NCYC];
  int valid_from  = 0;
  int drain_until = 0;
  int last_t      = -100;
  bit in_tile     = 1'b0;
  bit in_tile1    = 1'b0;
  int flip_at     = -1;
  int inj_cycle   = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: check outputs for cycle cyc, then drive inputs for it and update the model.
  task automatic step(input logic v, input logic [VW-1:0] d, input logic l, input logic r);
    logic [VW-1:0]    ed;
    logic [LANES-1:0] ev, ep;
    logic             ev1;
    int               t;
    feeder_state_e    es, es1;
    @(negedge clk);
    ed = '0; ev = '0; ep = '0;
    for (int i = 0; i < LANES; i++) begin
      t = cyc - 1 - i;
      if (t >= valid_from && hv[t]) begin
        ev[i] = 1'b1;
        ed[i*WIDTH +: WIDTH] = hd[t][i*WIDTH +: WIDTH];
      end
    end
`ifdef OPERAND_SKEW_FEEDER_PARITY_EN
    if (cyc == inj_cycle) begin
      ed[2*WIDTH] = ~ed[2*WIDTH];
      ep[2] = 1'b1;
    end
`endif
    es = (cyc < drain_until) ? DRAIN : (in_tile ? STREAM : IDLE);
    check("out_valid", 64'(out_valid), 64'(ev));
    check("out_data", 64'(out_data), 64'(ed));
    check("par_err", 64'(out_par_err), 64'(ep));
    check("tile_done", 64'(tile_done), 64'(last_t >= valid_from && cyc == last_t + LANES));
    check("in_ready", 64'(in_ready), 64'(cyc >= drain_until));
    check("busy", 64'(busy), 64'(es != IDLE));
    check("state", 64'(dbg_state), 64'(es));

    t   = cyc - 1;
    ev1 = (t >= valid_from) && (hv1[t] === 1'b1);
    es1 = in_tile1 ? STREAM : IDLE;
    check("l1_valid", 64'(out_valid1), 64'(ev1));
    check("l1_data", 64'(out_data1), ev1 ? 64'(hd[t][WIDTH-1:0]) : 64'd0);
    check("l1_tile_done", 64'(tile_done1), 64'(ev1 && hl[t]));
    check("l1_ready", 64'(in_ready1), 64'd1);
    check("l1_state", 64'(dbg_state1), 64'(es1));
    check("l1_busy", 64'(busy1), 64'(es1 != IDLE));
    check("l1_par_err", 64'(out_par_err1), 64'd0);

`ifdef OPERAND_SKEW_FEEDER_PARITY_EN
    if (cyc == flip_at)
      u_dut.g_lane[2].u_dl.stage[1][0] = ~u_dut.g_lane[2].u_dl.stage[1][0];
`endif

    rst = r; in_valid = v; in_data = d; in_last = l;
    hd[cyc]  = d;
    hl[cyc]  = l;
    hv[cyc]  = v && !r && (cyc >= drain_until);
    hv1[cyc] = v && !r;
    if (hv[cyc]) begin
      if (l) begin
        last_t      = cyc;
        drain_until = cyc + LANES;
        in_tile     = 1'b0;
      end else begin
        in_tile = 1'b1;
      end
    end
    if (hv1[cyc]) in_tile1 = !l;
    if (r) begin
      valid_from  = cyc + 1;
      drain_until = 0;
      in_tile     = 1'b0;
      in_tile1    = 1'b0;
    end
    cyc++;
    if (cyc >= NCYC) begin
      $display("FAIL cycle_budget cycle=%0d limit=%0d", cyc, NCYC);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < NCYC; k++) begin
      hv[k] = 1'b0; hv1[k] = 1'b0; hl[k] = 1'b0; hd[k] = '0;
    end
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // single-vector tile
    step(1'b1, 32'h44332211, 1'b1, 1'b0);
    idle(5);

    // three-vector tile, next tile offered continuously while draining
    step(1'b1, 32'hA1A2A3A4, 1'b0, 1'b0);
    step(1'b1, 32'hB1B2B3B4, 1'b0, 1'b0);
    step(1'b1, 32'hC1C2C3C4, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 32'hD0D1D2D3, 1'b0, 1'b0);
    step(1'b1, 32'hE5E6E7E8, 1'b1, 1'b0);
    idle(5);

    // bubble inside a tile
    step(1'b1, 32'h0F1E2D3C, 1'b0, 1'b0);
    step(1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
    step(1'b1, 32'h55AA55AA, 1'b1, 1'b0);
    idle(5);

    // reset in the middle of a tile
    step(1'b1, 32'h12345678, 1'b0, 1'b0);
    step(1'b1, 32'h9ABCDEF0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    idle(6);

`ifdef OPERAND_SKEW_FEEDER_PARITY_EN
    flip_at   = cyc + 2;
    inj_cycle = cyc + 3;
    step(1'b1, 32'h3C5A7E81, 1'b1, 1'b0);
    idle(6);
`endif

    // randomized traffic with occasional resets
    for (int k = 0; k < 500; k++) begin
      step(($urandom_range(0, 9) < 7), VW'($urandom()), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 99) == 0));
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
